// File: rtl/hex_display_pkg.sv
// Shared constants for hex_display_ctrl: register addresses, CTRL bit positions
// and the active-high gfedcba seven-segment table.
package hex_display_pkg;

  localparam logic [3:0] ADDR_NIBBLES   = 4'd0;
  localparam logic [3:0] ADDR_DECODE    = 4'd1;
  localparam logic [3:0] ADDR_BLINK     = 4'd2;
  localparam logic [3:0] ADDR_DP        = 4'd3;
  localparam logic [3:0] ADDR_CTRL      = 4'd4;
  localparam logic [3:0] ADDR_BLINK_DIV = 4'd5;
  localparam logic [3:0] ADDR_RAW_BASE  = 4'd8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PHASE_BIT = 1;

  // Index n holds the glyph for hex digit n (F at the top of the packed array).
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus bundle for hex_display_ctrl (zero-wait, combinational readdata).
interface hex_display_ctrl_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-high gfedcba segment decode.
module hex7seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG7_LUT[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller with per-digit decode/raw select, dp and blink.
// Optional macro HEX_BLINK_EN builds the blink prescaler and BLINK/BLINK_DIV registers.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int          NUM_DIGITS        = 6,
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter logic [31:0] DEFAULT_BLINK_DIV = 32'd12499999
) (
  input  logic                    clk,
  input  logic                    reset,
  hex_display_ctrl_if.slave       bus,
  output logic [8*NUM_DIGITS-1:0] hex_out,
  output logic                    blink_phase
);
  localparam int N = NUM_DIGITS;
  localparam logic [7:0] OFF_BYTE = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [4*N-1:0]     nibbles;
  logic [N-1:0]       decode, dp, blink_mask;
  logic [N-1:0][6:0]  raw;
  logic               enable;
  logic               wr;
  logic [N-1:0][7:0]  digit_nxt;
  logic [31:0]        rd;
  logic               unused_wd;

  assign wr        = bus.chipselect && !bus.write_n;
  assign unused_wd = ^bus.writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nibbles <= '0;
      decode  <= '1;
      dp      <= '0;
      enable  <= 1'b1;
      raw     <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_NIBBLES: nibbles <= bus.writedata[4*N-1:0];
        ADDR_DECODE:  decode  <= bus.writedata[N-1:0];
        ADDR_DP:      dp      <= bus.writedata[N-1:0];
        ADDR_CTRL:    enable  <= bus.writedata[CTRL_EN_BIT];
        default: begin
          for (int i = 0; i < N; i++)
            if (bus.address == ADDR_RAW_BASE + 4'(i)) raw[i] <= bus.writedata[6:0];
        end
      endcase
    end
  end

`ifdef HEX_BLINK_EN
  logic [31:0] blink_div, cnt;
  logic        phase;

  // A BLINK_DIV write restarts the period so the new rate begins from a known phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_mask <= '0;
      blink_div  <= DEFAULT_BLINK_DIV;
      cnt        <= '0;
      phase      <= 1'b0;
    end else begin
      if (wr && bus.address == ADDR_BLINK) blink_mask <= bus.writedata[N-1:0];
      if (wr && bus.address == ADDR_BLINK_DIV) begin
        blink_div <= bus.writedata;
        cnt       <= '0;
        phase     <= 1'b0;
      end else if (cnt == blink_div) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end
  assign blink_phase = phase;
`else
  logic unused_div;
  assign unused_div  = ^DEFAULT_BLINK_DIV;
  assign blink_mask  = '0;
  assign blink_phase = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_NIBBLES: rd[4*N-1:0] = nibbles;
      ADDR_DECODE:  rd[N-1:0]   = decode;
      ADDR_DP:      rd[N-1:0]   = dp;
      ADDR_CTRL: begin
        rd[CTRL_EN_BIT]    = enable;
        rd[CTRL_PHASE_BIT] = blink_phase;
      end
`ifdef HEX_BLINK_EN
      ADDR_BLINK:     rd[N-1:0] = blink_mask;
      ADDR_BLINK_DIV: rd        = blink_div;
`endif
      default: begin
        for (int i = 0; i < N; i++)
          if (bus.address == ADDR_RAW_BASE + 4'(i)) rd[6:0] = raw[i];
      end
    endcase
  end
  assign bus.readdata = rd;

  for (genvar i = 0; i < N; i++) begin : g_digit
    logic [6:0] dec_seg;
    logic [7:0] lit;

    hex7seg_decoder u_dec (.nibble(nibbles[4*i +: 4]), .seg(dec_seg));

    always_comb begin
      lit = {dp[i], decode[i] ? dec_seg : raw[i]};
      if (!enable || (blink_mask[i] && blink_phase)) lit = '0;
    end
    assign digit_nxt[i] = ACTIVE_LOW ? ~lit : lit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hex_out <= {N{OFF_BYTE}};
    else       hex_out <= digit_nxt;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: register reads checked inline, display
// and blink_phase expectations queued in a scoreboard and popped when sampled.
module tb_hex_display_ctrl;
  localparam int N = 6;
  localparam logic [47:0] ALL_OFF  = {N{8'hFF}};
  localparam logic [47:0] ALL_ZERO = {N{8'hC0}};
  localparam logic [47:0] BASE     = 48'hF9A4B0999282;
  localparam logic [47:0] BASE3    = 48'hF9A4B0999236;
  localparam logic [47:0] DARK0    = 48'hF9A4B09992FF;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [8*N-1:0]  hex_out;
  logic            blink_phase;
  int              nvec = 0;
  int              nerr = 0;

  typedef struct {
    string       tag;
    logic [47:0] hex;
    logic        ph;
  } exp_t;
  exp_t sb[$];

  hex_display_ctrl_if bus();

  hex_display_ctrl #(
    .NUM_DIGITS(N), .ACTIVE_LOW(1'b1), .DEFAULT_BLINK_DIV(32'd12499999)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .hex_out(hex_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1 chk(tag, 64'(bus.readdata), 64'(exp));
    bus.chipselect = 1'b0;
  endtask

  task automatic sb_push(input string tag, input logic [47:0] hex, input logic ph);
    exp_t e;
    e.tag = tag; e.hex = hex; e.ph = ph;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hex"}, 64'(hex_out), 64'(e.hex));
      chk({e.tag, "_phase"}, 64'(blink_phase), 64'(e.ph));
    end
  endtask

  initial begin
    bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;

    // Reset forces every digit dark, released on a falling edge.
    #2 reset = 1'b1;
    #1 sb_push("in_reset", ALL_OFF, 1'b0); sb_check();
    tick(); tick();
    sb_push("in_reset_held", ALL_OFF, 1'b0); sb_check();
    reset = 1'b0;
    tick();
    sb_push("first_edge", ALL_ZERO, 1'b0); sb_check();
`ifdef HEX_BLINK_EN
    bus_read("rd_div_reset", 4'd5, 32'd12499999);
`else
    bus_read("rd_div_reset", 4'd5, 32'd0);
`endif
    bus_read("rd_decode_reset", 4'd1, 32'h3F);
    bus_read("rd_ctrl_reset", 4'd4, 32'h1);

    // Nibble decode, one-edge output latency after the write edge.
    bus_write(4'd0, 32'h00123456);
    sb_push("nib_not_yet", ALL_ZERO, 1'b0); sb_check();
    tick();
    sb_push("nib_123456", BASE, 1'b0); sb_check();
    bus_read("rd_nibbles", 4'd0, 32'h00123456);
    bus_write(4'd0, 32'hFFFFFFFF);
    bus_read("rd_nibbles_trunc", 4'd0, 32'h00FFFFFF);
    tick();
    sb_push("nib_all_f", {N{8'h8E}}, 1'b0); sb_check();
    bus_write(4'd0, 32'h00123456);

    // Raw segments and dp on digit 0.
    bus_write(4'd1, 32'hFFFFFF3E);
    bus_write(4'd8, 32'h00000049);
    bus_write(4'd3, 32'h00000001);
    tick();
    sb_push("raw_dp_digit0", BASE3, 1'b0); sb_check();
    bus_read("rd_decode", 4'd1, 32'h3E);
    bus_read("rd_raw0", 4'd8, 32'h49);
    bus_read("rd_dp", 4'd3, 32'h1);
    bus_write(4'd14, 32'h7F);
    bus_read("rd_raw_oob", 4'd14, 32'h0);
    bus_read("rd_unmapped", 4'd6, 32'h0);

`ifdef HEX_BLINK_EN
    // Period of 4 clocks per phase; digit0 follows phase one edge later.
    bus_write(4'd2, 32'h1);
    bus_write(4'd5, 32'd3);
    for (int j = 0; j < 13; j++) begin
      sb_push("blink", (j >= 1 && (((j - 1) / 4) % 2 == 1)) ? DARK0 : BASE3, 1'((j / 4) % 2));
      sb_check();
      tick();
    end
    // Phase is 1 here; rewriting the divider restarts at phase 0.
    bus_write(4'd5, 32'd3);
    for (int m = 0; m < 6; m++) begin
      sb_push("restart", (m == 0 || (((m - 1) / 4) % 2 == 1)) ? DARK0 : BASE3, 1'((m / 4) % 2));
      sb_check();
      tick();
    end
    bus_read("rd_ctrl_phase", 4'd4, 32'h3);
    bus_read("rd_div", 4'd5, 32'd3);
    bus_read("rd_blink", 4'd2, 32'h1);
`else
    bus_write(4'd2, 32'h1);
    bus_write(4'd5, 32'd3);
    bus_read("rd_blink_absent", 4'd2, 32'h0);
    bus_read("rd_div_absent", 4'd5, 32'h0);
    for (int j = 0; j < 6; j++) begin
      sb_push("no_blink", BASE3, 1'b0); sb_check();
      tick();
    end
    bus_read("rd_ctrl_nophase", 4'd4, 32'h1);
`endif

    // Disable, then reset in the middle of blinking.
    bus_write(4'd4, 32'h0);
    tick();
    sb_push("disabled", ALL_OFF, blink_phase); sb_check();
    bus.address = 4'd4; bus.chipselect = 1'b1;
    #1 chk("rd_ctrl_en0", 64'(bus.readdata[0]), 64'd0);
    bus.chipselect = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1 sb_push("mid_reset", ALL_OFF, 1'b0); sb_check();
    tick();
    reset = 1'b0;
    tick();
    sb_push("after_reset", ALL_ZERO, 1'b0); sb_check();
    bus_read("rd_nib_def", 4'd0, 32'h0);
    bus_read("rd_decode_def", 4'd1, 32'h3F);
    bus_read("rd_dp_def", 4'd3, 32'h0);
    bus_read("rd_ctrl_def", 4'd4, 32'h1);
    bus_read("rd_raw0_def", 4'd8, 32'h0);
`ifdef HEX_BLINK_EN
    bus_read("rd_div_def", 4'd5, 32'd12499999);
    bus_read("rd_blink_def", 4'd2, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
